// File: rtl/ro_race_counter_if.sv
// Handshake and result bundle for the ring-oscillator race counter.
interface ro_race_counter_if #(
    parameter int WIDTH = 22
);
    logic             start;
    logic             ack;
    logic             en_a;
    logic             en_b;
    logic [WIDTH-1:0] count_a;
    logic [WIDTH-1:0] count_b;
    logic             busy;
    logic             done;
    logic             response;
    logic             tie;
    logic             timeout;

    modport master (
        output start, ack, en_a, en_b,
        input  count_a, count_b, busy, done, response, tie, timeout
    );

    modport slave (
        input  start, ack, en_a, en_b,
        output count_a, count_b, busy, done, response, tie, timeout
    );
endinterface

// File: rtl/ro_race_counter.sv
// Races two oscillator edge counters; the first to set TERM_BIT decides the PUF response bit.
module ro_race_counter #(
    parameter int          WIDTH     = 22,
    parameter int          TERM_BIT  = WIDTH - 1,
    parameter int          TMO_W     = 26,
    parameter int unsigned TMO_LIMIT = 2**TMO_W - 1
) (
    input  logic              clk,
    input  logic              reset,
    ro_race_counter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count_a;
    logic [WIDTH-1:0] r_count_b;
    logic [TMO_W-1:0] r_tmo;
    logic             r_busy;
    logic             r_done;
    logic             r_response;
    logic             r_tie;
    logic             r_timeout;

    // Terminal detection looks only at registered counts, so a terminal freezes the counters.
    logic w_term_a;
    logic w_term_b;
    logic w_tmo_hit;
    assign w_term_a  = r_count_a[TERM_BIT];
    assign w_term_b  = r_count_b[TERM_BIT];
    assign w_tmo_hit = (r_tmo == TMO_W'(TMO_LIMIT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_count_a  <= '0;
            r_count_b  <= '0;
            r_tmo      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_response <= 1'b0;
            r_tie      <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state    <= COUNT;
                        r_count_a  <= '0;
                        r_count_b  <= '0;
                        r_tmo      <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_response <= 1'b0;
                        r_tie      <= 1'b0;
                        r_timeout  <= 1'b0;
                    end else if (r_state == DONE && bus.ack) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                end
                COUNT: begin
                    if (w_term_a || w_term_b) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_response <= w_term_a && !w_term_b;
                        r_tie      <= w_term_a && w_term_b;
                        r_timeout  <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_response <= 1'b0;
                        r_tie      <= 1'b0;
                        r_timeout  <= 1'b1;
                    end else begin
                        r_count_a <= r_count_a + {{(WIDTH-1){1'b0}}, bus.en_a};
                        r_count_b <= r_count_b + {{(WIDTH-1){1'b0}}, bus.en_b};
                        r_tmo     <= r_tmo + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count_a  = r_count_a;
    assign bus.count_b  = r_count_b;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.response = r_response;
    assign bus.tie      = r_tie;
    assign bus.timeout  = r_timeout;
endmodule

// File: tb/tb_ro_race_counter.sv
// Randomized race bench: expected race outcomes are queued at launch and checked by a monitor on done.
module tb_ro_race_counter;
    localparam int WIDTH     = 4;
    localparam int TERM_BIT  = 3;
    localparam int TMO_W     = 5;
    localparam int TMO_LIMIT = 20;
    localparam int TERM_VAL  = 2**TERM_BIT;
    localparam int MAXSEQ    = 40;

    typedef struct {
        int ca;
        int cb;
        int resp;
        int tie;
        int tmo;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    exp_t exp_q[$];
    exp_t cur;
    bit   have_cur = 0;
    logic done_q   = 0;
    bit   in_done  = 0;

    ro_race_counter_if #(.WIDTH(WIDTH)) bus ();

    ro_race_counter #(
        .WIDTH(WIDTH), .TERM_BIT(TERM_BIT), .TMO_W(TMO_W), .TMO_LIMIT(TMO_LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_result(input string tag, input exp_t e);
        chk({tag, "_count_a"},  int'(bus.count_a),  e.ca);
        chk({tag, "_count_b"},  int'(bus.count_b),  e.cb);
        chk({tag, "_response"}, int'(bus.response), e.resp);
        chk({tag, "_tie"},      int'(bus.tie),      e.tie);
        chk({tag, "_timeout"},  int'(bus.timeout),  e.tmo);
    endtask

    // Monitor: pops an expectation on each done rising edge, then holds it while done stays high.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.done && !done_q) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                    have_cur <= 0;
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur <= 1;
                    chk_result("result", cur);
                    chk("busy_in_done", int'(bus.busy), 0);
                end
            end else if (bus.done && have_cur) begin
                chk_result("hold", cur);
            end
        end
        done_q <= bus.done;
    end

    task automatic noise();
        bus.en_a = 1'($urandom_range(0, 1));
        bus.en_b = 1'($urandom_range(0, 1));
    endtask

    // pa/pb: percent chance per cycle that each channel pulses.
    task automatic race(input int pa, input int pb, input bit end_ack);
        bit   ea[MAXSEQ];
        bit   eb[MAXSEQ];
        int   ca = 0, cb = 0, steps = 0, k;
        exp_t e;
        for (int i = 0; i < MAXSEQ; i++) begin
            ea[i] = ($urandom_range(0, 99) < pa);
            eb[i] = ($urandom_range(0, 99) < pb);
        end
        // Reference: count until a channel reaches 2**TERM_BIT or TMO_LIMIT cycles elapse.
        while (ca < TERM_VAL && cb < TERM_VAL && steps < TMO_LIMIT) begin
            ca += int'(ea[steps]);
            cb += int'(eb[steps]);
            steps++;
        end
        e.ca   = ca;
        e.cb   = cb;
        e.resp = (ca >= TERM_VAL && cb < TERM_VAL) ? 1 : 0;
        e.tie  = (ca >= TERM_VAL && cb >= TERM_VAL) ? 1 : 0;
        e.tmo  = (ca < TERM_VAL && cb < TERM_VAL) ? 1 : 0;
        exp_q.push_back(e);

        bus.start = 1'b1;
        bus.ack   = in_done;
        noise();
        @(negedge clk);
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        chk("busy_after_start", int'(bus.busy), 1);
        chk("done_after_start", int'(bus.done), 0);
        chk_result("cleared", '{0, 0, 0, 0, 0});

        k = 0;
        while (k < MAXSEQ) begin
            bus.en_a  = ea[k];
            bus.en_b  = eb[k];
            bus.start = (k > 0) && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (bus.done) break;
            k++;
        end
        bus.start = 1'b0;
        if (!bus.done) chk("race_done_bound", 0, 1);
        else           chk("race_latency", k, steps);

        repeat ($urandom_range(1, 3)) begin
            noise();
            @(negedge clk);
        end
        in_done = 1;
        if (end_ack) begin
            bus.ack = 1'b1;
            noise();
            @(negedge clk);
            bus.ack = 1'b0;
            in_done = 0;
            chk("done_after_ack", int'(bus.done), 0);
            chk("busy_after_ack", int'(bus.busy), 0);
            repeat (2) begin
                noise();
                @(negedge clk);
            end
            chk_result("idle_held", e);
        end
    endtask

    initial begin
        bool_init();
    end

    task automatic bool_init();
        int n;
        int probs[4];
        probs[0] = 0; probs[1] = 35; probs[2] = 70; probs[3] = 100;
        bus.start = 0; bus.ack = 0; bus.en_a = 0; bus.en_b = 0;
        reset = 0;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk_result("rst", '{0, 0, 0, 0, 0});
        repeat (2) @(negedge clk);
        reset = 1;
        noise();
        @(negedge clk);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_counts", int'(bus.count_a) + int'(bus.count_b), 0);

        race(100, 0, 1);    // A wins
        race(100, 100, 0);  // tie, left in DONE
        race(0, 0, 1);      // timeout, launched with start+ack together

        // Abort a race mid-flight with reset.
        bus.start = 1; bus.en_a = 0; bus.en_b = 1;
        @(negedge clk);
        bus.start = 0;
        n = 0;
        while (int'(bus.count_b) != 5 && n < 30) begin
            bus.en_a = ~bus.en_a;
            @(negedge clk);
            n++;
        end
        chk("abort_reach_5", int'(bus.count_b), 5);
        #2 reset = 0;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk_result("abort", '{0, 0, 0, 0, 0});
        @(negedge clk);
        reset = 1;
        repeat (2) begin
            noise();
            @(negedge clk);
        end
        chk("post_abort_busy", int'(bus.busy), 0);
        chk("post_abort_done", int'(bus.done), 0);

        for (int i = 0; i < 14; i++)
            race(probs[$urandom_range(0, 3)], probs[$urandom_range(0, 3)],
                 (i == 13) ? 1'b1 : 1'($urandom_range(0, 1)));

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask
endmodule

// File: doc/ro_race_counter.md
RO_RACE_COUNTER -- requirements
Module: ro_race_counter

Interface
REQ-001 Parameter WIDTH, 22, bit width of each edge counter.
REQ-002 Parameter TERM_BIT, WIDTH-1, counter bit whose assertion marks a channel terminal; legal range 0..WIDTH-1.
REQ-003 Parameter TMO_W, 26, bit width of the timeout cycle counter.
REQ-004 Parameter TMO_LIMIT, 2**TMO_W-1, number of COUNT cycles before timeout; legal range 1..2**TMO_W-1.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 reset  in  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-007 start  in  1  pulse; begins a race when FSM is IDLE or DONE.
REQ-008 ack  in  1  acknowledges result; returns FSM from DONE to IDLE.
REQ-009 en_a  in  1  synchronous edge pulse from oscillator channel A; one count per cycle high.
REQ-010 en_b  in  1  synchronous edge pulse from oscillator channel B; one count per cycle high.
REQ-011 count_a  out  WIDTH  channel A edge count.
REQ-012 count_b  out  WIDTH  channel B edge count.
REQ-013 busy  out  1  high while FSM is COUNT.
REQ-014 done  out  1  high while FSM is DONE.
REQ-015 response  out  1  PUF bit: 1 = A terminal first, 0 otherwise.
REQ-016 tie  out  1  both channels terminal in the same cycle.
REQ-017 timeout  out  1  race ended on TMO_LIMIT with neither channel terminal.

Function
REQ-018 FSM states SHALL be IDLE, COUNT, DONE; encoding is free.
REQ-019 IDLE/DONE + start=1 -> COUNT next cycle; same edge clears count_a, count_b, timeout counter, response, tie, timeout.
REQ-020 start SHALL be ignored in COUNT; start has priority over ack in DONE.
REQ-021 In COUNT, when neither count_a[TERM_BIT] nor count_b[TERM_BIT] is set and timeout not reached: count_a += en_a, count_b += en_b, timeout counter += 1.
REQ-022 Terminal check uses registered counter values; the cycle a terminal bit is seen, no counter increments and FSM -> DONE (counts frozen at the terminal value).
REQ-023 On DONE entry: A only terminal -> response=1, tie=0; B only -> response=0, tie=0; both -> response=0, tie=1.
REQ-024 In COUNT, timeout counter == TMO_LIMIT with no terminal bit set -> DONE, timeout=1, response=0, tie=0; terminal takes priority over timeout in the same cycle.
REQ-025 Counters SHALL never wrap; TERM_BIT is reached before wrap for all legal parameters.
REQ-026 DONE + ack=1 (start=0) -> IDLE next cycle; counts, response, tie, timeout retained until next start.
REQ-027 done, response, tie, timeout SHALL be stable throughout DONE.
REQ-028 en_a/en_b outside COUNT SHALL have no effect.

Reset
REQ-029 reset low SHALL asynchronously force IDLE, count_a=0, count_b=0, timeout counter=0, busy=0, done=0, response=0, tie=0, timeout=0.
REQ-030 reset low mid-race SHALL abort it with no result; after release FSM waits in IDLE for start.
REQ-031 First state change after reset release SHALL occur at the first posedge with reset high.

Verification (WIDTH=4, TERM_BIT=3, TMO_W=5, TMO_LIMIT=20)
REQ-032 start, en_a=1 constant, en_b=0 -> count_a=8 after 8 COUNT cycles, next cycle done=1, response=1, tie=0, count_b=0.
REQ-033 start, en_a=en_b=1 constant -> both reach 8 same cycle; done=1, tie=1, response=0.
REQ-034 start, en_a=en_b=0 -> after 20 COUNT cycles done=1, timeout=1, response=0, counts 0.
REQ-035 start, en_b=1, en_a toggling; reset low at count_b=5 -> all outputs 0 immediately, IDLE; start again -> fresh race from 0.
REQ-036 start pulsed during COUNT -> no effect; in DONE ack=1 -> IDLE, done=0, counts/response held; start and ack together in DONE -> new race.
